// File: rtl/mult_pkg.sv
// mult_pkg: shared widths, ALU function code and FSM state type for seq_multiplier
package mult_pkg;
    localparam int MULT_W = 32;
    localparam int MULT_ITERS = 32;
    localparam logic [2:0] ALU_F_ADD = 3'b010;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;
endpackage

// File: rtl/mult_ctrl.sv
// mult_ctrl: multiply sequencer (FSM, iteration counter, completed flag); ports: clk, rst, start_i -> load_o, run_o, last_o, completed_o
module mult_ctrl
    import mult_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic load_o,
    output logic run_o,
    output logic last_o,
    output logic completed_o
);
    mult_state_t state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic completed_q;
    logic cnt_last;
    assign cnt_last = cnt_q == 6'(MULT_ITERS - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            completed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            completed_q <= state_d == DONE;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                state_d = start_i ? RUN : IDLE;
                cnt_d   = start_i ? '0 : cnt_q;
            end
            RUN: begin
                state_d = cnt_last ? DONE : RUN;
                cnt_d   = cnt_q + 6'd1;
            end
            DONE:    state_d = start_i ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        load_o      = state_q == IDLE && start_i;
        run_o       = state_q == RUN;
        last_o      = state_q == RUN && cnt_last;
        completed_o = completed_q;
    end
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: 32x32 shift-add multiplier using the shared external ALU for every add
// Ports: clk, rst (async, active high); SrcAE/SrcBE operands, MultE start/hold;
// ALUOut/ALU_zero from the ALU, ALU_A/ALU_B to the ALU; hi/lo product, completed flag.
// Define MULT_SIGNED_EN for two's complement operands (magnitude multiply, negate at the end).
module seq_multiplier
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [MULT_W-1:0] SrcAE,
    input  logic [MULT_W-1:0] SrcBE,
    input  logic              MultE,
    input  logic [MULT_W-1:0] ALUOut,
    input  logic              ALU_zero,
    output logic [MULT_W-1:0] ALU_A,
    output logic [MULT_W-1:0] ALU_B,
    output logic [MULT_W-1:0] hi,
    output logic [MULT_W-1:0] lo,
    output logic              completed
);
    logic [MULT_W-1:0] hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d, a_mag, b_mag;
    logic [2*MULT_W-1:0] shifted, prod;
    logic load, run, last, carry;
    logic unused_zero;
    assign unused_zero = ALU_zero;
    mult_ctrl u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .start_i     (MultE),
        .load_o      (load),
        .run_o       (run),
        .last_o      (last),
        .completed_o (completed)
    );
    assign ALU_A = hi_q;
    assign ALU_B = (run && lo_q[0]) ? mcand_q : '0;
    // The ALU returns only 32 bits, so the carry-out is rebuilt from the operand and sum MSBs.
    assign carry = (ALU_A[31] & ALU_B[31]) | ((ALU_A[31] | ALU_B[31]) & ~ALUOut[31]);
    assign shifted = {carry, ALUOut, lo_q[MULT_W-1:1]};
`ifdef MULT_SIGNED_EN
    logic sign_q, sign_d;
    assign a_mag = SrcAE[31] ? -SrcAE : SrcAE;
    assign b_mag = SrcBE[31] ? -SrcBE : SrcBE;
    assign sign_d = load ? SrcAE[31] ^ SrcBE[31] : sign_q;
    assign prod = (last && sign_q) ? ~shifted + 64'd1 : shifted;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sign_q <= 1'b0;
        else     sign_q <= sign_d;
    end
`else
    assign a_mag = SrcAE;
    assign b_mag = SrcBE;
    assign prod = shifted;
    logic unused_last;
    assign unused_last = last;
`endif
    always_comb begin
        hi_d    = load ? '0 : run ? prod[2*MULT_W-1:MULT_W] : hi_q;
        lo_d    = load ? b_mag : run ? prod[MULT_W-1:0] : lo_q;
        mcand_d = load ? a_mag : mcand_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
        end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
        end
    end
    assign hi = hi_q;
    assign lo = lo_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: scoreboard bench for seq_multiplier with a behavioural ALU and product model
module tb_seq_multiplier;
    logic clk = 1'b0, rst = 1'b1, MultE = 1'b0;
    logic [31:0] SrcAE = '0, SrcBE = '0;
    logic [31:0] ALUOut, ALU_A, ALU_B, hi, lo;
    logic ALU_zero, completed;
    seq_multiplier dut (
        .clk       (clk),
        .rst       (rst),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .MultE     (MultE),
        .ALUOut    (ALUOut),
        .ALU_zero  (ALU_zero),
        .ALU_A     (ALU_A),
        .ALU_B     (ALU_B),
        .hi        (hi),
        .lo        (lo),
        .completed (completed)
    );
    assign ALUOut = ALU_A + ALU_B;
    assign ALU_zero = ALUOut == 32'd0;
    always #5 clk = ~clk;
    typedef struct {logic [63:0] p; int s;} exp_t;
    exp_t q[$];
    exp_t e;
    int tests = 0, fails = 0, cyc = 0;
    logic prev_c = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_SIGNED_EN
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
`else
        return {32'b0, a} * {32'b0, b};
`endif
    endfunction
    always @(negedge clk) begin
        if (completed && !prev_c) begin
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                e = q.pop_front();
                chk("product", {hi, lo}, e.p);
                chk("latency", 64'(cyc - e.s), 32);
            end
        end
        prev_c = completed;
    end
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        SrcAE = a;
        SrcBE = b;
        MultE = 1'b1;
        q.push_back('{model(a, b), cyc + 1});
    endtask
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b);
        int n;
        logic [63:0] p;
        p = model(a, b);
        start(a, b);
        n = 0;
        while (!completed && n < 40) begin
            @(negedge clk);
            n++;
            MultE = n < 25 ? 1'($urandom) : 1'b1;
            SrcAE = $urandom;
            SrcBE = $urandom;
        end
        chk("done_seen", {63'b0, completed}, 1);
        repeat (2) begin
            @(negedge clk);
            chk("hold_completed", {63'b0, completed}, 1);
            chk("hold_product", {hi, lo}, p);
        end
        MultE = 1'b0;
        @(negedge clk);
        chk("completed_fall", {63'b0, completed}, 0);
        chk("held_after_drop", {hi, lo}, p);
        chk("aluB_idle", {32'b0, ALU_B}, 0);
    endtask
    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_hi_lo", {hi, lo}, 0);
        chk("rst_completed", {63'b0, completed}, 0);
        chk("rst_alu", {ALU_A, ALU_B}, 0);
        rst = 1'b0;
        run_mult(32'h101, 32'h25);
        chk("vec_101x25", {hi, lo}, 64'h0000_0000_0000_2525);
        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef MULT_SIGNED_EN
        chk("vec_m1xm1", {hi, lo}, 64'h1);
`else
        chk("vec_ffxff", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
`endif
        run_mult(32'h1234_5678, 32'h0);
        chk("vec_x0", {hi, lo}, 64'h0);
        run_mult(32'd3, 32'd5);
        chk("vec_3x5", {hi, lo}, 64'd15);
        start(32'hDEAD_BEEF, 32'h1357_9BDF);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        MultE = 1'b0;
        #1;
        chk("abort_hi_lo", {hi, lo}, 0);
        chk("abort_completed", {63'b0, completed}, 0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_stays_idle", {hi, lo, 31'b0, completed}, 0);
        run_mult(32'hFFFF_FFFD, 32'd7);
`ifdef MULT_SIGNED_EN
        chk("vec_m3x7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
`else
        chk("vec_fffdx7", {hi, lo}, 64'h0000_0006_FFFF_FFEB);
`endif
        run_mult(32'h8000_0000, 32'h8000_0000);
        run_mult(32'h8000_0000, 32'h0000_0001);
        repeat (6) run_mult($urandom, $urandom);
        @(negedge clk);
        chk("pending", 64'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
